// File: rtl/hub_mem_master.sv
// Cog-side hub memory initiator: latches one command, waits for this cog's hub slot,
// drives the shared request lines for that slot only, then returns a lane-aligned read.
// Optional macro HUB_MEM_MASTER_SIGNEXT_EN adds req_sx_i for sign-extended byte/word reads.
module hub_mem_master #(
  parameter int unsigned COG_ID    = 0,
  parameter int unsigned NUM_SLOTS = 8
) (
  input  logic        clk_cog_i,
  input  logic        nres_i,
  input  logic        ena_bus_i,
  input  logic        req_i,
  input  logic        req_w_i,
  input  logic [1:0]  req_sz_i,
  input  logic [15:0] req_addr_i,
  input  logic [31:0] req_d_i,
`ifdef HUB_MEM_MASTER_SIGNEXT_EN
  input  logic        req_sx_i,
`endif
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rd_q_o,
  output logic        mem_w_o,
  output logic [3:0]  mem_wb_o,
  output logic [13:0] mem_a_o,
  output logic [31:0] mem_d_o,
  input  logic [31:0] mem_q_i
);

  localparam int unsigned SlotW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [SlotW-1:0] CogSlot = SlotW'(COG_ID);

  typedef enum logic [1:0] {StIdle, StWait, StCapt, StDone} state_e;

  state_e           state_q;
  logic [SlotW-1:0] slot_q;
  logic             w_q;
  logic [1:0]       sz_q;
  logic [15:0]      addr_q;
  logic [31:0]      d_q;
  logic             sx_q;
  logic             busy_q;
  logic             ack_q;
  logic [31:0]      rd_q_q;

  logic             grant;
  logic [3:0]       lane_wb;
  logic [31:0]      lane_d;
  logic [31:0]      byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      rd_align;

  assign grant = (state_q == StWait) && ena_bus_i && (slot_q == CogSlot);

  always_comb begin
    lane_wb = 4'b1111;
    lane_d  = d_q;
    case (sz_q)
      2'b00: begin
        lane_wb = 4'b0001 << addr_q[1:0];
        lane_d  = {4{d_q[7:0]}};
      end
      2'b01: begin
        lane_wb = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_d  = {2{d_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = mem_q_i >> {addr_q[1:0], 3'b000};
    half_sel = addr_q[1] ? mem_q_i[31:16] : mem_q_i[15:0];
    case (sz_q)
      2'b00:   rd_align = {{24{sx_q & byte_sel[7]}}, byte_sel[7:0]};
      2'b01:   rd_align = {{16{sx_q & half_sel[15]}}, half_sel};
      default: rd_align = mem_q_i;
    endcase
  end

  // Request lines are zero outside the owned slot so the hub can OR all cogs together.
  assign mem_w_o  = grant & w_q;
  assign mem_wb_o = grant ? lane_wb : 4'b0000;
  assign mem_a_o  = grant ? addr_q[15:2] : 14'd0;
  assign mem_d_o  = grant ? lane_d : 32'd0;

  assign busy_o = busy_q;
  assign ack_o  = ack_q;
  assign rd_q_o = rd_q_q;

  always_ff @(posedge clk_cog_i or negedge nres_i) begin
    if (!nres_i) begin
      state_q <= StIdle;
      slot_q  <= '0;
      w_q     <= 1'b0;
      sz_q    <= 2'b00;
      addr_q  <= 16'd0;
      d_q     <= 32'd0;
      sx_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      rd_q_q  <= 32'd0;
    end else begin
      ack_q <= 1'b0;
      if (ena_bus_i) begin
        slot_q <= slot_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          // The ack cycle still blocks a new command.
          if (req_i && !ack_q) begin
            w_q     <= req_w_i;
            sz_q    <= req_sz_i;
            addr_q  <= req_addr_i;
            d_q     <= req_d_i;
`ifdef HUB_MEM_MASTER_SIGNEXT_EN
            sx_q    <= req_sx_i;
`else
            sx_q    <= 1'b0;
`endif
            busy_q  <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (grant) begin
            state_q <= w_q ? StDone : StCapt;
          end
        end
        StCapt: begin
          rd_q_q  <= rd_align;
          state_q <= StDone;
        end
        StDone: begin
          ack_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hub_mem_master.sv
// Directed bench for hub_mem_master (COG_ID=3, NUM_SLOTS=8): vector table of single
// commands plus reset, busy-rejection and mid-operation reset sequences.
module tb_hub_mem_master;

  logic        clk = 1'b0;
  logic        nres = 1'b0;
  logic        ena_bus = 1'b1;
  logic        ena_toggle = 1'b0;
  logic        req = 1'b0;
  logic        req_w = 1'b0;
  logic [1:0]  req_sz = 2'b00;
  logic [15:0] req_addr = 16'd0;
  logic [31:0] req_d = 32'd0;
  logic        req_sx = 1'b0;
  logic        busy, ack, mem_w;
  logic [31:0] rd_q, mem_d;
  logic [3:0]  mem_wb;
  logic [13:0] mem_a;
  logic [31:0] mem_q = 32'd0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rd = 32'd0;

  hub_mem_master #(
    .COG_ID   (3),
    .NUM_SLOTS(8)
  ) dut (
    .clk_cog_i (clk),
    .nres_i    (nres),
    .ena_bus_i (ena_bus),
    .req_i     (req),
    .req_w_i   (req_w),
    .req_sz_i  (req_sz),
    .req_addr_i(req_addr),
    .req_d_i   (req_d),
`ifdef HUB_MEM_MASTER_SIGNEXT_EN
    .req_sx_i  (req_sx),
`endif
    .busy_o    (busy),
    .ack_o     (ack),
    .rd_q_o    (rd_q),
    .mem_w_o   (mem_w),
    .mem_wb_o  (mem_wb),
    .mem_a_o   (mem_a),
    .mem_d_o   (mem_d),
    .mem_q_i   (mem_q)
  );

  always #5 clk = ~clk;

  // ena_bus changes just after the rising edge; outputs are sampled on the falling edge.
  always @(posedge clk) begin
    #1;
    ena_bus = ena_toggle ? ~ena_bus : 1'b1;
  end

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [15:0] addr;
    logic [31:0] d;
    logic        sx;
    logic [31:0] q;
    logic [3:0]  e_wb;
    logic [13:0] e_a;
    logic [31:0] e_d;
    logic [31:0] e_rd;
    logic [31:0] e_rd_sx;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    req      = 1'b1;
    req_w    = v.w;
    req_sz   = v.sz;
    req_addr = v.addr;
    req_d    = v.d;
    req_sx   = v.sx;
  endtask

  // Scramble command inputs after acceptance so only latched values can reach the bus.
  task automatic scramble_cmd(input vec_t v);
    req      = 1'b0;
    req_w    = ~v.w;
    req_sz   = ~v.sz;
    req_addr = ~v.addr;
    req_d    = ~v.d;
    req_sx   = ~v.sx;
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic run_cmd(input vec_t v, input string tag, output int wait_n);
    logic        leak;
    logic        found;
    int          lat;
    logic [31:0] exp_rd;
    leak   = 1'b0;
    found  = 1'b0;
    wait_n = 0;
`ifdef HUB_MEM_MASTER_SIGNEXT_EN
    exp_rd = v.e_rd_sx;
`else
    exp_rd = v.e_rd;
`endif
    drive_cmd(v);
    @(negedge clk);
    scramble_cmd(v);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int n = 1; n <= 40; n++) begin
      if (mem_wb !== 4'b0000) begin
        found  = 1'b1;
        wait_n = n;
        break;
      end
      if (mem_a !== 14'd0 || mem_d !== 32'd0 || mem_w !== 1'b0) leak = 1'b1;
      @(negedge clk);
    end
    chk({tag, "_granted"}, {31'd0, found}, 32'd1);
    chk({tag, "_quiet"}, {31'd0, leak}, 32'd0);
    if (!found) return;
    chk({tag, "_mem_a"}, {18'd0, mem_a}, {18'd0, v.e_a});
    chk({tag, "_mem_wb"}, {28'd0, mem_wb}, {28'd0, v.e_wb});
    chk({tag, "_mem_d"}, mem_d, v.e_d);
    chk({tag, "_mem_w"}, {31'd0, mem_w}, {31'd0, v.w});
    // Hub memory registers on the grant edge: q is valid only in the following cycle.
    @(posedge clk);
    #1 mem_q = v.q;
    @(negedge clk);
    lat = 1;
    if (ack !== 1'b1) begin
      @(posedge clk);
      #1 mem_q = 32'h5A5A_C3C3;
      @(negedge clk);
      lat = 2;
      while (ack !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_latency"}, lat, v.w ? 32'd2 : 32'd3);
    chk({tag, "_busy_at_ack"}, {31'd0, busy}, 32'd0);
    if (!v.w) last_rd = exp_rd;
    chk({tag, "_rd_q"}, rd_q, last_rd);
    @(negedge clk);
    chk({tag, "_ack_pulse"}, {31'd0, ack}, 32'd0);
  endtask

  initial begin
    int   w_n;
    int   grants;
    int   acks;
    logic found;
    logic ack_seen;
    logic [13:0] g_a;
    vec_t v;

    //             w     sz     addr      d             sx    q             wb     a         d             rd            rd_sx
    vecs[0]  = '{1'b1, 2'b10, 16'h0100, 32'hDEADBEEF, 1'b0, 32'h00000000, 4'hF, 14'h0040, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 2'b10, 16'h0100, 32'h00000000, 1'b0, 32'hDEADBEEF, 4'hF, 14'h0040, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 2'b00, 16'h0103, 32'h123456A5, 1'b0, 32'h00000000, 4'h8, 14'h0040, 32'hA5A5A5A5, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 2'b00, 16'h0103, 32'h00000000, 1'b1, 32'hA5112233, 4'h8, 14'h0040, 32'h00000000, 32'h000000A5, 32'hFFFFFFA5};
    vecs[4]  = '{1'b0, 2'b01, 16'h0102, 32'h00000000, 1'b0, 32'h1234ABCD, 4'hC, 14'h0040, 32'h00000000, 32'h00001234, 32'h00001234};
    vecs[5]  = '{1'b0, 2'b01, 16'h0103, 32'h00000000, 1'b1, 32'h1234ABCD, 4'hC, 14'h0040, 32'h00000000, 32'h00001234, 32'h00001234};
    vecs[6]  = '{1'b1, 2'b01, 16'h0102, 32'h9999BEEF, 1'b0, 32'h00000000, 4'hC, 14'h0040, 32'hBEEFBEEF, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 2'b00, 16'h0001, 32'h00000000, 1'b1, 32'h11223344, 4'h2, 14'h0000, 32'h00000000, 32'h00000033, 32'h00000033};
    vecs[8]  = '{1'b0, 2'b01, 16'h0200, 32'h00000000, 1'b1, 32'h8001F00D, 4'h3, 14'h0080, 32'h00000000, 32'h0000F00D, 32'hFFFFF00D};
    vecs[9]  = '{1'b1, 2'b00, 16'h8002, 32'h0000007E, 1'b0, 32'h00000000, 4'h4, 14'h2000, 32'h7E7E7E7E, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 2'b11, 16'h0005, 32'h00000000, 1'b1, 32'hCAFEF00D, 4'hF, 14'h0001, 32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 2'b10, 16'hFFFC, 32'h01234567, 1'b0, 32'h00000000, 4'hF, 14'h3FFF, 32'h01234567, 32'h0,        32'h0};

    // Reset held with req toggling.
    req_w = 1'b1; req_sz = 2'b10; req_addr = 16'h0100; req_d = 32'hFFFF_FFFF;
    repeat (4) begin
      @(negedge clk);
      req = ~req;
    end
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_rd_q", rd_q, 32'd0);
    chk("rst_mem_w", {31'd0, mem_w}, 32'd0);
    chk("rst_mem_wb", {28'd0, mem_wb}, 32'd0);
    chk("rst_mem_a", {18'd0, mem_a}, 32'd0);
    chk("rst_mem_d", mem_d, 32'd0);

    // Release with ena_bus tied high: accepted in slot 0, granted in slot 3.
    nres = 1'b1;
    run_cmd(vecs[0], "first", w_n);
    chk("first_grant_delay", w_n, 32'd3);

    // Table of single commands with ena_bus toggling every clock.
    ena_toggle = 1'b1;
    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i), w_n);
    end

    // Second req while busy must be ignored.
    v = vecs[0];
    drive_cmd(v);
    @(negedge clk);
    scramble_cmd(v);
    chk("rej_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    req = 1'b1; req_w = 1'b1; req_sz = 2'b10; req_addr = 16'h0400; req_d = 32'h0BAD_0BAD;
    @(negedge clk);
    req = 1'b0;
    grants = 0;
    acks = 0;
    g_a = 14'd0;
    for (int n = 0; n < 60; n++) begin
      if (mem_wb !== 4'b0000) begin
        grants++;
        g_a = mem_a;
      end
      if (ack === 1'b1) acks++;
      @(negedge clk);
    end
    chk("rej_grants", grants, 32'd1);
    chk("rej_acks", acks, 32'd1);
    chk("rej_mem_a", {18'd0, g_a}, 32'h0040);

    // Reset during the capture cycle of a read aborts it without ack.
    v = vecs[1];
    drive_cmd(v);
    @(negedge clk);
    scramble_cmd(v);
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (mem_wb !== 4'b0000) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("mid_granted", {31'd0, found}, 32'd1);
    @(posedge clk);
    #1 mem_q = v.q;
    nres = 1'b0;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_ack", {31'd0, ack}, 32'd0);
    chk("mid_rd_q", rd_q, 32'd0);
    repeat (3) @(negedge clk);
    nres = 1'b1;
    ack_seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ack === 1'b1) ack_seen = 1'b1;
    end
    chk("mid_no_ack", {31'd0, ack_seen}, 32'd0);
    chk("mid_idle", {31'd0, busy}, 32'd0);
    last_rd = 32'd0;
    run_cmd(vecs[3], "post_rst", w_n);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
